kyber_op_ctrl: RTL and testbench
================================

# kyber_op_ctrl

Operation sequencer for the polynomial arithmetic core. Accepts one operation request (NTT, INVNTT, MULT, ADDSUB) via a start/mode handshake, then drives the `mode` and `clk_counter` buses consumed directly by the address generator. It also drives the coefficient RAM read/write enables and a done pulse. The per-mode issue length and write-back latency are fixed to match the address generator's schedule and the datapath pipeline depth.

## Interface
- No parameters; all lengths and latencies are package constants.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode_in`  in  2  operation code: NTT=0, INVNTT=1, MULT=2, ADDSUB=3.
- `abort`  in  1  synchronous cancel of the running operation.
- `mode`  out  2  latched operation code to the address generator.
- `clk_counter`  out  8  schedule counter to the address generator.
- `stage`  out  3  `clk_counter[7:5]`; valid in NTT/INVNTT only.
- `rd_en`  out  1  RAM read strobe.
- `wr_en`  out  1  RAM write strobe.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Per-mode constants: ISSUE / LAT / LAST = ISSUE+LAT-1.
  - NTT: 224 / 7 / 230.
  - INVNTT: 224 / 7 / 230.
  - MULT: 128 / 13 / 140.
  - ADDSUB: 64 / 5 / 68.
- States and transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DONE when `clk_counter == LAST`.
  - RUN -> IDLE on `abort`. No done pulse is issued.
  - DONE -> IDLE unconditionally.
- IDLE behaviour:
  - On `start`, latch `mode_in` into `mode` and clear `clk_counter` to 0.
  - `start` is ignored in RUN and DONE. Requests are not queued.
- RUN behaviour:
  - `clk_counter` increments by 1 every cycle.
  - `rd_en = (clk_counter < ISSUE)`.
  - `wr_en = (clk_counter >= LAT) && (clk_counter < ISSUE+LAT)`.
  - Both enables are combinational from state, counter and `mode`.
- Exit from RUN: `clk_counter` clears to 0 when entering DONE or IDLE. `mode` holds its last value.
- Counter range: the counter never wraps; the maximum value is 230. A counter value above LAST is unreachable. If it does occur, treat it as LAST.
- Simultaneous events in RUN:
  - `abort` together with the LAST cycle: abort wins, giving IDLE with no done pulse.
  - `start` together with `abort`: `start` is ignored.

## Timing
- Reset values: state=IDLE, `mode`=0, `clk_counter`=0, `stage`=0, `rd_en`=0, `wr_en`=0, `busy`=0, `done`=0.
- Reset mid-operation: all outputs return to the reset values immediately (asynchronous). Any writes still in flight are dropped.
- Request acceptance: `start` high at edge T puts the block in RUN from T+1, with `clk_counter`=0 and `rd_en`=1 in that cycle.
- Operation length: `busy` is high for exactly LAST+1 cycles (NTT 231, MULT 141, ADDSUB 69). `done` is high in the following cycle.
- Back-to-back: minimum spacing between accepted starts is LAST+3 cycles (RUN, DONE, IDLE).
- Registered outputs: `mode`, `clk_counter` and `done` are registered with no combinational path from inputs. `busy` and `stage` decode from registers only.

## Structure
- Shared package `kyber_pkg` holds:
  - mode codes NTT/INVNTT/MULT/ADDSUB (the address generator uses the same codes);
  - the ISSUE/LAT constants per mode;
  - the FSM state encoding.
- One sub-module, `kyber_op_len`: combinational, `mode` -> {issue, lat, last}. It is reused by the datapath control for pipeline bookkeeping.

## Test plan
- Reset mid-operation: assert `rst` during RUN at `clk_counter`=50 -> all outputs 0 in the same cycle; IDLE after release; next `start` is accepted normally.
- NTT: `start` with `mode_in`=0 ->
  - `busy` for 231 cycles;
  - `rd_en` for `clk_counter` 0..223, `wr_en` for 7..230;
  - `stage` steps 0..6 every 32 cycles, with `stage`=7 from count 224;
  - `done` pulse at `clk_counter`=0 in DONE.
- MULT then ADDSUB, back-to-back:
  - MULT: `wr_en` first high at count 13, last at 140; `done` after 141 busy cycles.
  - ADDSUB: `rd_en` 0..63, `wr_en` 5..68.
- Start while busy: pulse `start` with `mode_in`=3 at NTT count 100 -> ignored; `mode` stays 0; exactly one `done`.
- Abort: `abort` at INVNTT count 80 -> IDLE next cycle; `rd_en`=`wr_en`=0; no `done`; next `start` accepted.
- Abort on the LAST cycle: `abort` at ADDSUB count 68 -> no `done`, state IDLE.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared definitions for the polynomial core: mode codes, per-mode schedule constants, sequencer states.
package kyber_pkg;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INVNTT = 2'd1,
    MODE_MULT   = 2'd2,
    MODE_ADDSUB = 2'd3
  } kyber_mode_e;

  // Issue length matches the address generator schedule; latency matches datapath depth.
  localparam logic [7:0] NTT_ISSUE    = 8'd224;
  localparam logic [7:0] NTT_LAT      = 8'd7;
  localparam logic [7:0] MULT_ISSUE   = 8'd128;
  localparam logic [7:0] MULT_LAT     = 8'd13;
  localparam logic [7:0] ADDSUB_ISSUE = 8'd64;
  localparam logic [7:0] ADDSUB_LAT   = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } op_state_e;

endpackage

// File: rtl/kyber_op_len.sv
// Combinational mode -> {issue, lat, last} lookup; shared with the datapath control.
module kyber_op_len
  import kyber_pkg::*;
(
  input  logic [1:0] i_mode,
  output logic [7:0] o_issue,
  output logic [7:0] o_lat,
  output logic [7:0] o_last
);

  always_comb begin
    o_issue = NTT_ISSUE;
    o_lat   = NTT_LAT;
    case (i_mode)
      MODE_NTT,
      MODE_INVNTT: begin
        o_issue = NTT_ISSUE;
        o_lat   = NTT_LAT;
      end
      MODE_MULT: begin
        o_issue = MULT_ISSUE;
        o_lat   = MULT_LAT;
      end
      MODE_ADDSUB: begin
        o_issue = ADDSUB_ISSUE;
        o_lat   = ADDSUB_LAT;
      end
      default: begin
        o_issue = NTT_ISSUE;
        o_lat   = NTT_LAT;
      end
    endcase
    o_last = o_issue + o_lat - 8'd1;
  end

endmodule

// File: rtl/kyber_op_ctrl.sv
// Operation sequencer: accepts one request, then drives mode/clk_counter to the address generator,
// RAM read/write strobes and a one-cycle done pulse.
module kyber_op_ctrl
  import kyber_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_in,
  input  logic       abort,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic [2:0] stage,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  op_state_e  r_state;
  op_state_e  w_state_nxt;
  logic [1:0] r_mode;
  logic [1:0] w_mode_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic [7:0] w_issue;
  logic [7:0] w_lat;
  logic [7:0] w_last;
  logic       w_run;

  kyber_op_len u_op_len (
    .i_mode  (r_mode),
    .o_issue (w_issue),
    .o_lat   (w_lat),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is tested before the LAST compare so it wins on the final cycle; ">=" absorbs any overshoot.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_mode_nxt  = mode_in;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt >= w_last) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 8'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 2'd0;
      r_cnt  <= 8'd0;
      r_done <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign w_run       = (r_state == ST_RUN);
  assign mode        = r_mode;
  assign clk_counter = r_cnt;
  assign stage       = r_cnt[7:5];
  assign busy        = w_run;
  assign done        = r_done;
  assign rd_en       = w_run && (r_cnt < w_issue);
  assign wr_en       = w_run && (r_cnt >= w_lat) && (r_cnt <= w_last);

endmodule

// File: tb/tb_kyber_op_ctrl.sv
// Directed bench for kyber_op_ctrl with hand-computed per-mode expectations.
module tb_kyber_op_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode_in;
  logic       abort;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic [2:0] stage;
  logic       rd_en;
  logic       wr_en;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  kyber_op_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode_in     (mode_in),
    .abort       (abort),
    .mode        (mode),
    .clk_counter (clk_counter),
    .stage       (stage),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request from IDLE and checks the whole operation; abort_at/start_at < 0 disables injection.
  task automatic run_op(input string name, input logic [1:0] m,
                        input int exp_busy, input int exp_rd, input int exp_wr_first,
                        input int exp_wr_last, input int exp_done,
                        input int abort_at, input int start_at);
    int cyc = 0;
    int rd_n = 0;
    int rd_first = -1;
    int rd_last = -1;
    int wr_first = -1;
    int wr_last = -1;
    int bad_cnt = 0;
    int bad_stage = 0;
    int bad_mode = 0;
    logic [7:0] c8;
    start   = 1'b1;
    mode_in = m;
    tick();
    start   = 1'b0;
    mode_in = 2'd0;
    check({name, ".first_cycle_rd"}, {31'd0, rd_en}, 32'd1);
    while (busy && cyc < 400) begin
      c8 = cyc[7:0];
      if (clk_counter != c8) bad_cnt++;
      if (m < 2'd2 && stage != c8[7:5]) bad_stage++;
      if (mode != m) bad_mode++;
      if (rd_en) begin
        rd_n++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (wr_en) begin
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
      end
      if (cyc == abort_at) abort = 1'b1;
      if (cyc == start_at) begin
        start   = 1'b1;
        mode_in = 2'd3;
      end
      tick();
      abort   = 1'b0;
      start   = 1'b0;
      mode_in = 2'd0;
      cyc++;
    end
    check({name, ".busy_cycles"}, cyc, exp_busy);
    check({name, ".counter_steps_bad"}, bad_cnt, 0);
    if (m < 2'd2) check({name, ".stage_bad"}, bad_stage, 0);
    check({name, ".mode_bad"}, bad_mode, 0);
    check({name, ".rd_cycles"}, rd_n, exp_rd);
    check({name, ".rd_first"}, rd_first, 0);
    check({name, ".rd_last"}, rd_last, exp_rd - 1);
    check({name, ".wr_first"}, wr_first, exp_wr_first);
    check({name, ".wr_last"}, wr_last, exp_wr_last);
    check({name, ".done_after_run"}, {31'd0, done}, exp_done);
    check({name, ".cnt_after_run"}, {24'd0, clk_counter}, 32'd0);
    check({name, ".rd_after_run"}, {31'd0, rd_en}, 32'd0);
    check({name, ".wr_after_run"}, {31'd0, wr_en}, 32'd0);
    tick();
    check({name, ".done_pulse_end"}, {31'd0, done}, 32'd0);
    check({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({name, ".mode_held"}, {30'd0, mode}, {30'd0, m});
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode_in = 2'd0;
    abort   = 1'b0;
    tick();
    tick();
    check("reset.mode", {30'd0, mode}, 32'd0);
    check("reset.cnt", {24'd0, clk_counter}, 32'd0);
    check("reset.stage", {29'd0, stage}, 32'd0);
    check("reset.rd", {31'd0, rd_en}, 32'd0);
    check("reset.wr", {31'd0, wr_en}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_no_start.busy", {31'd0, busy}, 32'd0);

    // Async reset mid-MULT at count 50: outputs clear before the next edge.
    start   = 1'b1;
    mode_in = 2'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("midrst.cnt_before", {24'd0, clk_counter}, 32'd50);
    rst = 1'b1;
    #1;
    check("midrst.mode", {30'd0, mode}, 32'd0);
    check("midrst.cnt", {24'd0, clk_counter}, 32'd0);
    check("midrst.stage", {29'd0, stage}, 32'd0);
    check("midrst.rd", {31'd0, rd_en}, 32'd0);
    check("midrst.wr", {31'd0, wr_en}, 32'd0);
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check("midrst.done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst.idle_after", {31'd0, busy}, 32'd0);
    run_op("addsub_after_rst", 2'd3, 69, 64, 5, 68, 1, -1, -1);

    // NTT with a start pulse (mode 3) at count 100 that must be ignored.
    run_op("ntt", 2'd0, 231, 224, 7, 230, 1, -1, 100);

    // MULT then ADDSUB back-to-back.
    run_op("mult", 2'd2, 141, 128, 13, 140, 1, -1, -1);
    run_op("addsub", 2'd3, 69, 64, 5, 68, 1, -1, -1);

    // INVNTT aborted at count 80; abort and start together at the same time.
    run_op("invntt_abort", 2'd1, 81, 81, 7, 80, 0, 80, 80);
    run_op("invntt_full", 2'd1, 231, 224, 7, 230, 1, -1, -1);

    // Abort coinciding with the LAST cycle of ADDSUB.
    run_op("addsub_abort_last", 2'd3, 69, 64, 5, 68, 0, 68, -1);
    run_op("mult_after_abort", 2'd2, 141, 128, 13, 140, 1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
